div_sequencer: RTL



---
 rtl/div_pkg.sv | 30 +++
 rtl/div_sequencer_if.sv | 28 ++
 rtl/div_sequencer_addsub_unit.sv | 14 +
 rtl/div_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: default width, state encoding, counter sizing.
package div_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [3:0] EncIdle  = 4'd0;
  localparam logic [3:0] EncInit  = 4'd1;
  localparam logic [3:0] EncIter  = 4'd2;
  localparam logic [3:0] EncDone  = 4'd3;
  localparam logic [3:0] EncPreA  = 4'd4;
  localparam logic [3:0] EncPreB  = 4'd5;
  localparam logic [3:0] EncPostQ = 4'd6;
  localparam logic [3:0] EncPostR = 4'd7;

  typedef enum logic [3:0] {
    StIdle  = EncIdle,
    StInit  = EncInit,
    StIter  = EncIter,
    StDone  = EncDone,
    StPreA  = EncPreA,
    StPreB  = EncPreB,
    StPostQ = EncPostQ,
    StPostR = EncPostR
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/result bundle of div_sequencer; signed_op exists only when DIV_SIGNED_EN is defined.
interface div_sequencer_if #(
  parameter int unsigned WIDTH = div_pkg::DefaultWidth
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic             signed_op;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef DIV_SIGNED_EN
  modport master (output start, dividend, divisor, signed_op,
                  input busy, done, quotient, remainder, div_by_zero);
  modport slave  (input start, dividend, divisor, signed_op,
                  output busy, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input busy, done, quotient, remainder, div_by_zero);
  modport slave  (input start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`endif
endinterface

// File: rtl/div_sequencer_addsub_unit.sv
// Shared adder/subtractor: sum = a + (b ^ {sub}) + sub, so sub=1 gives a - b with cout = (a >= b).
module addsub_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
  end
endmodule

// File: rtl/div_sequencer.sv
// Restoring divider sequencer, one trial subtraction per clock through a single addsub_unit.
// Build option: DIV_SIGNED_EN adds signed_op and the PRE_A/PRE_B/POST_Q/POST_R sign-fixup states.
module div_sequencer
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic clk,
  input logic rst,
  div_sequencer_if.slave bus
);
  localparam int unsigned    CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  r_q, r_d, q_q, q_d, d_q, d_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]  quot_q, quot_d, rem_q, rem_d;
`ifdef DIV_SIGNED_EN
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
`endif

  logic [WIDTH-1:0]  add_a, add_b, add_sum;
  logic              add_sub, add_cout;
  logic [WIDTH-1:0]  r_sh;
  logic              ovf, success;

  assign r_sh    = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign ovf     = r_q[WIDTH-1];
  assign success = ovf | add_cout;

  // Operand mux: negations in the signed states are computed as 0 - x.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    unique case (state_q)
      StIter:  begin add_a = r_sh; add_b = d_q; add_sub = 1'b1; end
      StPreA:  begin add_b = q_q;  add_sub = 1'b1; end
      StPreB:  begin add_b = d_q;  add_sub = 1'b1; end
      StPostQ: begin add_b = q_q;  add_sub = 1'b1; end
      StPostR: begin add_b = r_q;  add_sub = 1'b1; end
      default: ;
    endcase
  end

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_SIGNED_EN
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
`endif
    unique case (state_q)
      StIdle: begin
        busy_d = bus.start;
        if (bus.start) begin
          state_d = StInit;
          q_d     = bus.dividend;
          d_d     = bus.divisor;
`ifdef DIV_SIGNED_EN
          neg_a_d = bus.signed_op & bus.dividend[WIDTH-1];
          neg_b_d = bus.signed_op & bus.divisor[WIDTH-1];
`endif
        end
      end
      StInit: begin
        cnt_d = '0;
        r_d   = '0;
        if (d_q == '0) begin
          q_d     = '1;
          r_d     = q_q;
          zero_d  = 1'b1;
          state_d = StDone;
        end else begin
          zero_d  = 1'b0;
`ifdef DIV_SIGNED_EN
          state_d = StPreA;
`else
          state_d = StIter;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      StPreA: begin
        if (neg_a_q) q_d = add_sum;
        state_d = StPreB;
      end
      StPreB: begin
        if (neg_b_q) d_d = add_sum;
        state_d = StIter;
      end
      StPostQ: begin
        if (neg_a_q ^ neg_b_q) q_d = add_sum;
        state_d = StPostR;
      end
      StPostR: begin
        if (neg_a_q) r_d = add_sum;
        state_d = StDone;
      end
`endif
      StIter: begin
        q_d = {q_q[WIDTH-2:0], success};
        r_d = success ? add_sum : r_sh;
        if (cnt_q == LastCnt) begin
`ifdef DIV_SIGNED_EN
          state_d = StPostQ;
`else
          state_d = StDone;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        quot_d  = q_q;
        rem_d   = r_q;
        dbz_d   = zero_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_SIGNED_EN
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV_SIGNED_EN
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
